// File: rtl/circular_right_rotate_seq_if.sv
// Request/result bundle for circular_right_rotate_seq.
//   master : requester side (drives in_valid/a/b/o_ready, sees in_ready/o/o_valid)
//   slave  : rotator side
// When ROTR_DIR_EN is defined a 1-bit dir signal is added (0 = right, 1 = left).
interface circular_right_rotate_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] o;
  logic        o_valid;
  logic        o_ready;
`ifdef ROTR_DIR_EN
  logic        dir;
`endif

  modport master (
`ifdef ROTR_DIR_EN
    output dir,
`endif
    output in_valid, a, b, o_ready,
    input  in_ready, o, o_valid
  );

  modport slave (
`ifdef ROTR_DIR_EN
    input  dir,
`endif
    input  in_valid, a, b, o_ready,
    output in_ready, o, o_valid
  );
endinterface

// File: rtl/circular_right_rotate_seq.sv
// Multi-cycle 32-bit circular rotator. Rotates by at most STEP positions per
// clock until the requested amount b[4:0] is consumed.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave modport (in_valid/in_ready/a/b request, o/o_valid/o_ready result)
// Optional feature macro ROTR_DIR_EN: adds bus.dir, captured at accept;
// dir=1 rotates left with identical timing. Default build rotates right only.
module circular_right_rotate_seq #(
  parameter int STEP = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  circular_right_rotate_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

  localparam logic [4:0] STEP_W = 5'(STEP);

  state_t      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [31:0] o_q, o_d;
  logic [4:0]  rem_q, rem_d;
  logic [4:0]  k;
  logic        left;

`ifdef ROTR_DIR_EN
  logic dir_q, dir_d;
  assign left = dir_q;
`else
  assign left = 1'b0;
`endif

  // b[31:5] carries no meaning for a 32-bit rotate.
  logic unused_b;
  assign unused_b = ^bus.b[31:5];

  // Rotate via a doubled word so any k in 0..31 is a single shift.
  function automatic logic [31:0] rot(input logic [31:0] w, input logic [4:0] amt,
                                      input logic lft);
    logic [63:0] dbl;
    dbl = {w, w};
    if (lft) begin
      dbl = dbl << amt;
      return dbl[63:32];
    end
    dbl = dbl >> amt;
    return dbl[31:0];
  endfunction

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    o_d     = o_q;
`ifdef ROTR_DIR_EN
    dir_d   = dir_q;
`endif
    k = (rem_q < STEP_W) ? rem_q : STEP_W;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.a;
          rem_d  = bus.b[4:0];
`ifdef ROTR_DIR_EN
          dir_d  = bus.dir;
`endif
          if (bus.b[4:0] == 5'd0) begin
            state_d = DONE;
            o_d     = bus.a;
          end else begin
            state_d = ROT;
          end
        end
      end
      ROT: begin
        work_d = rot(work_q, k, left);
        rem_d  = rem_q - k;
        // Result register only updates on entry to DONE, so o holds its
        // previous value through IDLE/ROT.
        if (rem_q == k) begin
          state_d = DONE;
          o_d     = work_d;
        end
      end
      DONE: begin
        if (bus.o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      o_q     <= '0;
`ifdef ROTR_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      o_q     <= o_d;
`ifdef ROTR_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o        = o_q;

endmodule

// File: doc/circular_right_rotate_seq.md
Name: circular_right_rotate_seq

Overview:
Multi-cycle 32-bit circular right rotator with valid/ready handshakes on input and output. It is the counterpart of the datapath's combinational left rotate and is used where area matters more than latency, for example in crypto/hash round helpers. It rotates by up to STEP bit positions per clock until the requested amount is consumed.

Parameters:
STEP, 1, maximum bit positions rotated per cycle; legal range 1..31; any value in range is legal, not only powers of two.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  a/b present a request.
in_ready  output  1  block can accept a request; high only in IDLE.
a  input  32  operand to rotate.
b  input  32  rotate amount; only b[4:0] is used; b[31:5] is ignored.
o  output  32  rotated result; valid while o_valid is high.
o_valid  output  1  result available.
o_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rst_n low at a clk edge): state goes to IDLE, o=0, o_valid=0, internal remaining count=0. in_ready is high in the first cycle after reset.
- Reset mid-operation: any in-flight request is discarded, no result is produced, and outputs return to their reset values on the next edge.
- States: IDLE, ROT, DONE. in_ready = (state==IDLE). o_valid = (state==DONE).
- IDLE: on in_valid & in_ready, capture a into the working register and b[4:0] into the remaining count (rem).
  - rem==0 -> DONE.
  - otherwise -> ROT.
- ROT: each cycle, rotate the working register right by k = min(STEP, rem), then rem -= k. When rem reaches 0 in a cycle -> DONE on the same edge.
- Latency: o_valid rises ceil(n/STEP)+1 cycles after the acceptance edge, where n = b[4:0]. For n=0 the latency is 1 cycle.
- DONE: o and o_valid are held stable until o_ready is high.
  - On o_valid & o_ready -> IDLE; in_ready is high the next cycle.
  - No same-cycle accept while in DONE; back-to-back throughput is therefore latency+1 cycles per request.
- o equals the working register in DONE. o is unchanged from its last value in IDLE/ROT, except after reset, when it is 0.
- Result definition: o = (a >> n) | (a << (32-n)), computed mod 32; n=0 gives o=a.
- in_valid asserted while in_ready is low is ignored; the requester must hold the request.
- a and b changing while not accepted has no effect.

Optional Feature:
- Macro: ROTR_DIR_EN.
- Defined: adds input port dir (1 bit), captured at acceptance. dir=0 rotates right (as above); dir=1 rotates left by n with identical timing. In ROT, each step rotates k positions left.
- Undefined: no dir port; right rotation only.

Test Plan:
- STEP=1, a=0x80000001, b=1 -> o=0xC0000000, o_valid 2 cycles after accept; o_ready=1 -> in_ready high the following cycle.
- STEP=1, a=0x12345678, b=0 -> o=0x12345678 one cycle after accept; b=0xFFFFFFE0 (b[4:0]=0) gives the same result.
- STEP=1, a=0x80000001, b=31 -> o=0x00000003 after 32 cycles; b=0x25 (n=5) on a=0x000000FF -> o=0xF8000007.
- STEP=4, a=0x12345678, b=8 -> o=0x78123456 after 3 cycles; b=9 -> o=0x3C091A2B after 4 cycles.
- Backpressure: hold o_ready=0 for 10 cycles in DONE -> o and o_valid stable, in_ready low, new in_valid ignored; release -> single handshake, then IDLE.
- Reset mid-ROT (STEP=1, b=20, rst_n low at cycle 5) -> o=0 and o_valid=0 next cycle, in_ready high. With ROTR_DIR_EN, dir=1, a=0x80000001, b=1 -> o=0x00000003.
